// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: opcode encodings, exception codes, controller FSM
// states and small decode helpers shared by the memory access controller.
package mem_access_ctrl_pkg;

  // Decoded MEM-stage opcodes (MIPS primary opcode values).
  localparam logic [7:0] INST_LB  = 8'h20;
  localparam logic [7:0] INST_LH  = 8'h21;
  localparam logic [7:0] INST_LWL = 8'h22;
  localparam logic [7:0] INST_LW  = 8'h23;
  localparam logic [7:0] INST_LBU = 8'h24;
  localparam logic [7:0] INST_LHU = 8'h25;
  localparam logic [7:0] INST_LWR = 8'h26;
  localparam logic [7:0] INST_SB  = 8'h28;
  localparam logic [7:0] INST_SH  = 8'h29;
  localparam logic [7:0] INST_SWL = 8'h2A;
  localparam logic [7:0] INST_SW  = 8'h2B;
  localparam logic [7:0] INST_SWR = 8'h2E;

  // Exception codes reported to CP0.
  localparam int EXC_ADEL = 4;
  localparam int EXC_ADES = 5;
  localparam int EXC_DBE  = 7;
  localparam int EXC_RI   = 10;

  typedef enum logic [1:0] {
    MEMC_IDLE = 2'd0,
    MEMC_BUS  = 2'd1,
    MEMC_DONE = 2'd2,
    MEMC_ERR  = 2'd3
  } memc_state_e;

  function automatic logic mem_is_load(input logic [7:0] inst);
    case (inst)
      INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU, INST_LWL, INST_LWR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic mem_is_store(input logic [7:0] inst);
    case (inst)
      INST_SB, INST_SH, INST_SW, INST_SWL, INST_SWR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Unaligned-word left/right group.
  function automatic logic mem_is_lr(input logic [7:0] inst);
    case (inst)
      INST_LWL, INST_LWR, INST_SWL, INST_SWR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Natural alignment: halfwords need a[0]=0, words need a=0.
  function automatic logic mem_misaligned(input logic [7:0] inst, input logic [1:0] a);
    case (inst)
      INST_LH, INST_LHU, INST_SH: return a[0];
      INST_LW, INST_SW:           return |a;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: MEM-stage request/response and data-bus signals.
// slave = the controller, master = pipeline + bus environment.
interface mem_access_ctrl_if #(parameter int EXC_W = 5);
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       inst;
  logic [31:0]      addr;
  logic [31:0]      store_data;
  logic [31:0]      rt_old;
  logic             resp_valid;
  logic [31:0]      load_data;
  logic             exc_valid;
  logic [EXC_W-1:0] exc_code;
  logic             stall;
  logic [31:0]      bus_addr;
  logic             bus_read;
  logic             bus_write;
  logic [3:0]       bus_byte_en;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_rdata;
  logic             bus_ack;

  modport slave (
    input  req_valid, inst, addr, store_data, rt_old, bus_rdata, bus_ack,
    output req_ready, resp_valid, load_data, exc_valid, exc_code, stall,
           bus_addr, bus_read, bus_write, bus_byte_en, bus_wdata
  );

  modport master (
    output req_valid, inst, addr, store_data, rt_old, bus_rdata, bus_ack,
    input  req_ready, resp_valid, load_data, exc_valid, exc_code, stall,
           bus_addr, bus_read, bus_write, bus_byte_en, bus_wdata
  );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// mem_lane_align: combinational lane steering for the data bus.
// Produces byte enables and lane-replicated store data, and extracts,
// extends or merges the load result from the returned bus word.
// MEM_UNALIGNED_LR_EN adds the LWL/LWR/SWL/SWR lane paths.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [7:0]  i_inst,
  input  logic [1:0]  i_a,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rt_old,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);
  logic [4:0]  w_sh_a;   // 8*a
  logic [4:0]  w_sh_na;  // 8*(3-a)
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_sh_a  = {i_a, 3'b000};
  assign w_sh_na = {~i_a, 3'b000};
  assign w_byte  = 8'(i_rdata >> w_sh_a);
  assign w_half  = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Lane enables and store data by access size.
  always_comb begin
    o_byte_en = 4'b0000;
    o_wdata   = '0;
    case (i_inst)
      INST_LB, INST_LBU: o_byte_en = 4'b0001 << i_a;
      INST_LH, INST_LHU: o_byte_en = i_a[1] ? 4'b1100 : 4'b0011;
      INST_LW:           o_byte_en = 4'b1111;
      INST_SB: begin
        o_byte_en = 4'b0001 << i_a;
        o_wdata   = {4{i_store_data[7:0]}};
      end
      INST_SH: begin
        o_byte_en = i_a[1] ? 4'b1100 : 4'b0011;
        o_wdata   = {2{i_store_data[15:0]}};
      end
      INST_SW: begin
        o_byte_en = 4'b1111;
        o_wdata   = i_store_data;
      end
`ifdef MEM_UNALIGNED_LR_EN
      INST_LWL, INST_LWR: o_byte_en = 4'b1111;
      INST_SWL: begin
        o_byte_en = 4'b1111 >> (~i_a);
        o_wdata   = i_store_data >> w_sh_na;
      end
      INST_SWR: begin
        o_byte_en = 4'b1111 << i_a;
        o_wdata   = i_store_data << w_sh_a;
      end
`endif
      default: ;
    endcase
  end

  // Load result: lane select + extension, or merge into rt for LWL/LWR.
  always_comb begin
    o_load_data = '0;
    case (i_inst)
      INST_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
      INST_LBU: o_load_data = {24'd0, w_byte};
      INST_LH:  o_load_data = {{16{w_half[15]}}, w_half};
      INST_LHU: o_load_data = {16'd0, w_half};
      INST_LW:  o_load_data = i_rdata;
`ifdef MEM_UNALIGNED_LR_EN
      INST_LWL: o_load_data = (i_rdata << w_sh_na) | (i_rt_old & (32'h00FF_FFFF >> w_sh_a));
      INST_LWR: o_load_data = (i_rdata >> w_sh_a) | (i_rt_old & ~(32'hFFFF_FFFF >> w_sh_a));
`endif
      default: ;
    endcase
  end

`ifndef MEM_UNALIGNED_LR_EN
  // rt_old only feeds the LWL/LWR merge.
  logic w_unused_rt_old;
  assign w_unused_rt_old = ^i_rt_old;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one MEM-stage load/store onto the single-ported
// data bus, stalls the pipeline until ack, and reports AdEL/AdES/DBE/RI.
// Optional macro MEM_UNALIGNED_LR_EN enables LWL/LWR/SWL/SWR; without it
// those opcodes raise RI with no bus access.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,  // bus cycles before DBE, 1..255
  parameter int EXC_W   = 5
)(
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus
);

`ifdef MEM_UNALIGNED_LR_EN
  localparam bit LR_EN = 1'b1;
`else
  localparam bit LR_EN = 1'b0;
`endif

  memc_state_e      r_state, w_state_nxt;
  logic [7:0]       r_inst;
  logic [31:0]      r_addr, r_sdata, r_rt_old, r_load_data;
  logic [7:0]       r_cnt;
  logic [EXC_W-1:0] r_exc_code, w_exc_nxt;
  logic             w_ready, w_resp, w_exc_vld, w_stall;
  logic             w_in_bus, w_tmo;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata, w_ld;

  assign w_in_bus = (r_state == MEMC_BUS);
  // Last permitted wait cycle; an ack arriving in it still wins.
  assign w_tmo    = (r_cnt == 8'(TIMEOUT - 1));

  mem_lane_align u_align (
    .i_inst       (r_inst),
    .i_a          (r_addr[1:0]),
    .i_rdata      (bus.bus_rdata),
    .i_store_data (r_sdata),
    .i_rt_old     (r_rt_old),
    .o_byte_en    (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_ld)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= MEMC_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_exc_nxt   = '0;
    w_ready     = 1'b0;
    w_resp      = 1'b0;
    w_exc_vld   = 1'b0;
    w_stall     = 1'b1;
    case (r_state)
      MEMC_IDLE: begin
        w_ready = 1'b1;
        w_stall = 1'b0;
        if (bus.req_valid) begin
          if (mem_is_lr(bus.inst) && !LR_EN) begin
            w_state_nxt = MEMC_ERR;
            w_exc_nxt   = EXC_W'(EXC_RI);
          end else if (mem_misaligned(bus.inst, bus.addr[1:0])) begin
            w_state_nxt = MEMC_ERR;
            w_exc_nxt   = mem_is_store(bus.inst) ? EXC_W'(EXC_ADES) : EXC_W'(EXC_ADEL);
          end else if (mem_is_load(bus.inst) || mem_is_store(bus.inst)) begin
            w_state_nxt = MEMC_BUS;
          end else begin
            w_state_nxt = MEMC_DONE;
          end
        end
      end
      MEMC_BUS: begin
        if (bus.bus_ack) begin
          w_state_nxt = MEMC_DONE;
        end else if (w_tmo) begin
          w_state_nxt = MEMC_ERR;
          w_exc_nxt   = EXC_W'(EXC_DBE);
        end
      end
      MEMC_DONE: begin
        w_resp      = 1'b1;
        w_stall     = 1'b0;
        w_state_nxt = MEMC_IDLE;
      end
      MEMC_ERR: begin
        w_resp      = 1'b1;
        w_exc_vld   = 1'b1;
        w_state_nxt = MEMC_IDLE;
      end
      default: w_state_nxt = MEMC_IDLE;
    endcase
  end

  // Request latch, wait counter, load result and exception code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst      <= '0;
      r_addr      <= '0;
      r_sdata     <= '0;
      r_rt_old    <= '0;
      r_load_data <= '0;
      r_cnt       <= '0;
      r_exc_code  <= '0;
    end else begin
      if (r_state == MEMC_IDLE && bus.req_valid) begin
        r_inst      <= bus.inst;
        r_addr      <= bus.addr;
        r_sdata     <= bus.store_data;
        r_rt_old    <= bus.rt_old;
        r_load_data <= '0;
      end
      if (w_in_bus && bus.bus_ack) r_load_data <= w_ld;
      r_cnt <= w_in_bus ? r_cnt + 8'd1 : 8'd0;
      if (w_state_nxt == MEMC_ERR) r_exc_code <= w_exc_nxt;
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.resp_valid  = w_resp;
  assign bus.exc_valid   = w_exc_vld;
  assign bus.exc_code    = w_exc_vld ? r_exc_code : '0;
  assign bus.stall       = w_stall;
  assign bus.load_data   = r_load_data;
  assign bus.bus_read    = w_in_bus && mem_is_load(r_inst);
  assign bus.bus_write   = w_in_bus && mem_is_store(r_inst);
  assign bus.bus_addr    = w_in_bus ? {r_addr[31:2], 2'b00} : '0;
  assign bus.bus_byte_en = w_in_bus ? w_be : 4'b0000;
  assign bus.bus_wdata   = w_in_bus ? w_wdata : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed + randomized checks of mem_access_ctrl
// against a byte-level behavioural model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int TMO = 255;
`ifdef MEM_UNALIGNED_LR_EN
  localparam bit LR_EN = 1'b1;
`else
  localparam bit LR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_access_ctrl_if #(.EXC_W(5)) bus_if ();

  mem_access_ctrl #(.TIMEOUT(TMO), .EXC_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          lat;
    int          nstb;
    logic        got, ready0, excv, ld_chk, rd, wr, stall_end, stall_after, bad_bus;
    logic [31:0] ld, excc, baddr, wd, wmask;
    logic [3:0]  be;
  } res_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Expected outcome from the architectural rules, byte by byte.
  function automatic res_t model(input logic [7:0] inst, input logic [31:0] addr, sd, rt, rdata,
                                 input int waits);
    res_t e;
    int a, size;
    bit ld, st, lr, sgn;
    logic [7:0] mb[4], rb[4], sb[4];
    logic [31:0] v;
    e = '{default: 0};
    a = int'(addr[1:0]);
    for (int k = 0; k < 4; k++) begin
      mb[k] = rdata[8*k +: 8];
      rb[k] = rt[8*k +: 8];
      sb[k] = sd[8*k +: 8];
    end
    ld   = inst inside {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU, INST_LWL, INST_LWR};
    st   = inst inside {INST_SB, INST_SH, INST_SW, INST_SWL, INST_SWR};
    lr   = inst inside {INST_LWL, INST_LWR, INST_SWL, INST_SWR};
    sgn  = inst inside {INST_LB, INST_LH};
    size = (inst inside {INST_LB, INST_LBU, INST_SB}) ? 1 :
           (inst inside {INST_LH, INST_LHU, INST_SH}) ? 2 : 4;
    e.wmask = 32'hFFFF_FFFF;
    if (lr && !LR_EN) begin
      e.lat = 2; e.excv = 1; e.excc = 10; e.stall_end = 1;
      return e;
    end
    if ((ld || st) && !lr && (a % size) != 0) begin
      e.lat = 2; e.excv = 1; e.excc = st ? 5 : 4; e.stall_end = 1;
      return e;
    end
    if (!ld && !st) begin
      e.lat = 2; e.ld_chk = 1; e.ld = 0;
      return e;
    end
    e.rd = ld; e.wr = st;
    e.baddr = addr & ~32'h3;
    if (inst == INST_SWL || inst == INST_SWR) begin
      e.wmask = 0;
      for (int i = 0; i < 4; i++) begin
        if ((inst == INST_SWL && i <= a) || (inst == INST_SWR && i >= a)) begin
          e.be[i] = 1'b1;
          e.wmask[8*i +: 8] = 8'hFF;
          e.wd[8*i +: 8] = (inst == INST_SWL) ? sb[3-a+i] : sb[i-a];
        end
      end
    end else if (inst == INST_LWL || inst == INST_LWR) begin
      e.be = 4'hF;
    end else begin
      for (int i = 0; i < size; i++) e.be[a+i] = 1'b1;
      if (st) for (int k = 0; k < 4; k++) e.wd[8*k +: 8] = sb[k % size];
    end
    if (inst == INST_LWL) begin
      for (int i = 0; i <= a; i++) rb[3-a+i] = mb[i];
      for (int k = 0; k < 4; k++) v[8*k +: 8] = rb[k];
    end else if (inst == INST_LWR) begin
      for (int i = a; i < 4; i++) rb[i-a] = mb[i];
      for (int k = 0; k < 4; k++) v[8*k +: 8] = rb[k];
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mb[a+i];
      if (sgn) for (int i = 8*size; i < 32; i++) v[i] = v[8*size-1];
    end
    if (waits < 0 || waits >= TMO) begin
      e.nstb = TMO; e.lat = TMO + 2; e.excv = 1; e.excc = 7; e.stall_end = 1;
    end else begin
      e.nstb = waits + 1; e.lat = waits + 3; e.ld_chk = ld; e.ld = v;
    end
    return e;
  endfunction

  // Issue one request (called #1 after a posedge, controller idle) and
  // play the bus: ack after 'waits' strobe cycles, or never if waits<0.
  task automatic run_op(input logic [7:0] inst, input logic [31:0] addr, sd, rt, rdata,
                        input int waits, output res_t o);
    int stb;
    o = '{default: 0};
    o.ready0 = bus_if.req_ready;
    bus_if.req_valid  = 1'b1;
    bus_if.inst       = inst;
    bus_if.addr       = addr;
    bus_if.store_data = sd;
    bus_if.rt_old     = rt;
    bus_if.bus_rdata  = rdata;
    o.lat = 1;
    stb = 0;
    while (!o.got && o.lat < TMO + 20) begin
      @(posedge clk); #1;
      bus_if.req_valid = 1'b0;
      o.lat++;
      if (bus_if.resp_valid) begin
        o.got       = 1'b1;
        o.ld        = bus_if.load_data;
        o.excv      = bus_if.exc_valid;
        o.excc      = 32'(bus_if.exc_code);
        o.stall_end = bus_if.stall;
        bus_if.bus_ack = 1'b0;
      end else begin
        if (bus_if.bus_read || bus_if.bus_write) begin
          if (stb == 0) begin
            o.rd = bus_if.bus_read; o.wr = bus_if.bus_write;
            o.baddr = bus_if.bus_addr; o.be = bus_if.bus_byte_en; o.wd = bus_if.bus_wdata;
          end else if (o.rd !== bus_if.bus_read || o.wr !== bus_if.bus_write ||
                       o.baddr !== bus_if.bus_addr || o.be !== bus_if.bus_byte_en ||
                       o.wd !== bus_if.bus_wdata) begin
            o.bad_bus = 1'b1;
          end
          if (!bus_if.stall || bus_if.req_ready) o.bad_bus = 1'b1;
          stb++;
        end
        bus_if.bus_ack = (waits >= 0 && stb == waits + 1);
      end
    end
    bus_if.bus_ack = 1'b0;
    o.nstb = stb;
    @(posedge clk); #1;
    o.stall_after = bus_if.stall;
  endtask

  task automatic check_op(input string t, input res_t w, input res_t o);
    chk({t, ".ready"}, 32'(o.ready0), 32'd1);
    chk({t, ".resp"}, 32'(o.got), 32'd1);
    chk({t, ".lat"}, o.lat, w.lat);
    chk({t, ".exc_valid"}, 32'(o.excv), 32'(w.excv));
    if (w.excv) chk({t, ".exc_code"}, o.excc, w.excc);
    if (w.ld_chk) chk({t, ".load_data"}, o.ld, w.ld);
    chk({t, ".strobe_cycles"}, o.nstb, w.nstb);
    chk({t, ".stall_at_resp"}, 32'(o.stall_end), 32'(w.stall_end));
    chk({t, ".stall_after"}, 32'(o.stall_after), 32'd0);
    if (w.nstb > 0 && o.nstb > 0) begin
      chk({t, ".bus_read"}, 32'(o.rd), 32'(w.rd));
      chk({t, ".bus_write"}, 32'(o.wr), 32'(w.wr));
      chk({t, ".bus_addr"}, o.baddr, w.baddr);
      chk({t, ".byte_en"}, 32'(o.be), 32'(w.be));
      chk({t, ".wdata"}, o.wd & w.wmask, w.wd & w.wmask);
      chk({t, ".bus_stable"}, 32'(o.bad_bus), 32'd0);
    end
  endtask

  initial begin
    res_t o, w;
    logic [7:0]  ops[13];
    logic [7:0]  op;
    logic [31:0] ad, sd, rt, rd;
    ops = '{INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU, INST_SB, INST_SH, INST_SW,
            INST_LWL, INST_LWR, INST_SWL, INST_SWR, 8'h00};
    bus_if.req_valid = 1'b0; bus_if.inst = '0; bus_if.addr = '0;
    bus_if.store_data = '0; bus_if.rt_old = '0; bus_if.bus_rdata = '0; bus_if.bus_ack = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.req_ready", 32'(bus_if.req_ready), 32'd1);
    chk("rst.resp_valid", 32'(bus_if.resp_valid), 32'd0);
    chk("rst.exc_valid", 32'(bus_if.exc_valid), 32'd0);
    chk("rst.exc_code", 32'(bus_if.exc_code), 32'd0);
    chk("rst.stall", 32'(bus_if.stall), 32'd0);
    chk("rst.load_data", bus_if.load_data, 32'd0);
    chk("rst.strobes", 32'({bus_if.bus_read, bus_if.bus_write}), 32'd0);
    chk("rst.byte_en", 32'(bus_if.bus_byte_en), 32'd0);
    chk("rst.wdata", bus_if.bus_wdata, 32'd0);
    chk("rst.bus_addr", bus_if.bus_addr, 32'd0);

    // LB / LBU at 0x1003, two wait states.
    run_op(INST_LB, 32'h1003, 32'h0, 32'h0, 32'h80AA_55CC, 2, o);
    check_op("lb", model(INST_LB, 32'h1003, 32'h0, 32'h0, 32'h80AA_55CC, 2), o);
    chk("lb.ld_k", o.ld, 32'hFFFF_FF80);
    chk("lb.be_k", 32'(o.be), 32'h8);
    chk("lb.lat_k", o.lat, 5);
    run_op(INST_LBU, 32'h1003, 32'h0, 32'h0, 32'h80AA_55CC, 2, o);
    check_op("lbu", model(INST_LBU, 32'h1003, 32'h0, 32'h0, 32'h80AA_55CC, 2), o);
    chk("lbu.ld_k", o.ld, 32'h0000_0080);

    // SH at 0x2002.
    run_op(INST_SH, 32'h2002, 32'h1234_BEEF, 32'h0, 32'h0, 1, o);
    check_op("sh", model(INST_SH, 32'h2002, 32'h1234_BEEF, 32'h0, 32'h0, 1), o);
    chk("sh.wd_k", o.wd, 32'hBEEF_BEEF);
    chk("sh.addr_k", o.baddr, 32'h2000);

    // Address errors.
    run_op(INST_LW, 32'h3001, 32'h0, 32'h0, 32'h0, 0, o);
    check_op("lw_adel", model(INST_LW, 32'h3001, 32'h0, 32'h0, 32'h0, 0), o);
    chk("lw_adel.code_k", o.excc, 32'd4);
    run_op(INST_SW, 32'h3002, 32'h55, 32'h0, 32'h0, 0, o);
    check_op("sw_ades", model(INST_SW, 32'h3002, 32'h55, 32'h0, 32'h0, 0), o);
    chk("sw_ades.code_k", o.excc, 32'd5);

    // Timeout, then ack on the final permitted cycle.
    run_op(INST_LW, 32'h4000, 32'h0, 32'h0, 32'hDEAD_BEEF, -1, o);
    check_op("tmo", model(INST_LW, 32'h4000, 32'h0, 32'h0, 32'hDEAD_BEEF, -1), o);
    chk("tmo.strobes_k", o.nstb, 255);
    run_op(INST_LW, 32'h4000, 32'h0, 32'h0, 32'hDEAD_BEEF, TMO - 1, o);
    check_op("ack_last", model(INST_LW, 32'h4000, 32'h0, 32'h0, 32'hDEAD_BEEF, TMO - 1), o);

    // Reset while BUS, then a late ack.
    bus_if.req_valid = 1'b1; bus_if.inst = INST_LW; bus_if.addr = 32'h6000;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstbus.pre_read", 32'(bus_if.bus_read), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstbus.read", 32'(bus_if.bus_read), 32'd0);
    chk("rstbus.ready", 32'(bus_if.req_ready), 32'd1);
    chk("rstbus.resp", 32'(bus_if.resp_valid), 32'd0);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus_if.bus_ack = 1'b0;
    chk("late_ack.resp", 32'(bus_if.resp_valid), 32'd0);
    chk("late_ack.ready", 32'(bus_if.req_ready), 32'd1);
    chk("late_ack.read", 32'(bus_if.bus_read), 32'd0);

    // LWL at 0x5001 (merge with the feature, RI without it).
    run_op(INST_LWL, 32'h5001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, o);
    check_op("lwl", model(INST_LWL, 32'h5001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0), o);
    if (LR_EN) chk("lwl.ld_k", o.ld, 32'hCCDD_3344);
    else       chk("lwl.code_k", o.excc, 32'd10);

    // Non-memory opcode completes without a bus access.
    run_op(8'h00, 32'h7000, 32'h0, 32'h0, 32'h0, 0, o);
    check_op("nonmem", model(8'h00, 32'h7000, 32'h0, 32'h0, 32'h0, 0), o);

    // Randomized mix.
    for (int i = 0; i < 80; i++) begin
      int wt;
      op = ops[$urandom_range(0, 12)];
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
      sd = $urandom; rt = $urandom; rd = $urandom;
      wt = int'($urandom_range(0, 3));
      w = model(op, ad, sd, rt, rd, wt);
      run_op(op, ad, sd, rt, rd, wt, o);
      check_op($sformatf("rnd%0d_op%02h", i, op), w, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences decoded load/store instructions (LB/LH/LW/LBU/LHU/SB/SH/SW, plus optional LWL/LWR/SWL/SWR) from the MEM stage onto the single-ported data bus.
- Drives byte enables, lane alignment and sign/zero extension.
- Holds the pipeline stalled until the bus acks.
- Reports address-error and bus-error exceptions to the CP0/exception logic.

Parameters:
- TIMEOUT, 255: bus cycles to wait for bus_ack before raising a bus error; must fit in 8 bits.
- EXC_W, 5: width of exc_code.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  MEM stage presents an access
- req_ready  out  1  controller can accept (IDLE state)
- inst  in  8  decoded opcode, INST_* encoding from defs.v
- addr  in  32  effective address
- store_data  in  32  rt value, used for stores
- rt_old  in  32  current rt value, used as the merge base for LWL/LWR
- resp_valid  out  1  one-cycle completion pulse
- load_data  out  32  extended/merged load result, valid with resp_valid
- exc_valid  out  1  exception pulse, same cycle as resp_valid
- exc_code  out  EXC_W  4=AdEL, 5=AdES, 7=DBE, 10=RI
- stall  out  1  freeze upstream pipeline
- bus_addr  out  32  word-aligned address, addr & ~3
- bus_read  out  1  read strobe
- bus_write  out  1  write strobe
- bus_byte_en  out  4  lane enables, bit k = bytes [8k+7:8k]
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  bus completion, one cycle

Behaviour:
- Reset: state=IDLE. All outputs 0 except req_ready=1. Timeout counter=0. Reset mid-access aborts the access with no response; the strobes drop the next edge.
- Byte order is little-endian. In the rules below, a = addr[1:0].
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch inst/addr/store_data/rt_old, then:
    - misaligned access → ERR;
    - non-memory inst → DONE with load_data=0 and no exception;
    - otherwise → BUS.
  - BUS: bus_read or bus_write held high with stable addr/byte_en/wdata; stall=1.
    - bus_ack → DONE; load_data is formed from bus_rdata and registered.
    - counter reaching TIMEOUT → ERR with code 7.
  - DONE: resp_valid=1 for one cycle, stall=0 → IDLE.
  - ERR: resp_valid=1 and exc_valid=1 with exc_code for one cycle; no bus strobe ever issued → IDLE.
- stall=1 in every state except IDLE and DONE.
- Latency: request accepted at edge N; strobe visible N+1. Ack sampled at edge M gives resp_valid in cycle M+1.
  - Zero-wait-state bus: 3 cycles request-to-response.
  - Address error: 2 cycles.
- Misalignment: halfword ops require a[0]=0; word ops require a=0. Loads raise 4, stores raise 5.
- Byte enables:
  - byte: 1<<a;
  - halfword: 0011 for a=0, 1100 for a=2;
  - word: 1111.
- Store data: SB replicates the byte to all 4 lanes; SH replicates the halfword to both halves.
- Load data: selected lane; LB/LH sign-extend, LBU/LHU zero-extend.
- bus_ack while IDLE/DONE/ERR is ignored.
- bus_ack in the same cycle the counter hits TIMEOUT: ack wins.
- req_valid while req_ready=0 is ignored; upstream holds it under stall.

Optional Feature:
- Macro: MEM_UNALIGNED_LR_EN.
- Defined: LWL/LWR/SWL/SWR never address-fault; all use a word-aligned access.
  - LWL: memory bytes 0..a overwrite rt_old bytes 3-a..3.
  - LWR: memory bytes a..3 overwrite rt_old bytes 0..3-a.
  - SWL: byte_en bits 0..a; rt bytes 3-a..3 shifted to lanes 0..a.
  - SWR: byte_en bits a..3; rt bytes 0..3-a shifted to lanes a..3.
- Undefined: these four insts go straight to ERR with exc_code 10 (RI); no bus access.

Decomposition:
- Shared package (defs.v): EXC_ADEL/EXC_ADES/EXC_DBE/EXC_RI constants and the MEMC_IDLE/BUS/DONE/ERR state encodings. INST_* codes are reused unchanged.
- One combinational sub-module, mem_lane_align: inst, a, bus_rdata, store_data, rt_old → byte_en, wdata, load_data.
- The FSM, latching and timeout stay in mem_access_ctrl.

Test Plan:
- LB at 0x1003, ack after 2 waits, rdata=0x80AA55CC → byte_en=1000, resp_valid 5 cycles after accept, load_data=0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH at 0x2002, store_data=0x1234BEEF → bus_addr=0x2000, byte_en=1100, wdata=0xBEEFBEEF, bus_write held until ack; one resp_valid, exc_valid=0.
- LW at 0x3001 → no bus strobe, resp_valid and exc_valid 2 cycles after accept, exc_code=4. SW at 0x3002 → exc_code=5.
- LW at 0x4000 with ack never returned, TIMEOUT=255 → bus_read high 255 cycles, then exc_code=7, stall releases. Ack on the final cycle → normal completion, no exception.
- rst=1 while in BUS → next cycle strobes=0, req_ready=1, no resp_valid. A late bus_ack after reset is ignored.
- MEM_UNALIGNED_LR_EN defined: LWL at 0x5001, rt_old=0x11223344, rdata=0xAABBCCDD → load_data=0xCCDD3344. Without the macro → exc_code=10, no strobe.
